// File: rtl/lc3_pkg.sv
// LC-3 control sequencer shared definitions: FSM state encoding,
// datapath mux/ALU encodings and ISA opcode constants.
package lc3_pkg;

  typedef enum logic [5:0] {
    S00    = 6'd0,
    S01    = 6'd1,
    S02    = 6'd2,
    S03    = 6'd3,
    S04    = 6'd4,
    S05    = 6'd5,
    S06    = 6'd6,
    S07    = 6'd7,
    S09    = 6'd9,
    S10    = 6'd10,
    S11    = 6'd11,
    S12    = 6'd12,
    S14    = 6'd14,
    S15    = 6'd15,
    S16    = 6'd16,
    S18    = 6'd18,
    S20    = 6'd20,
    S21    = 6'd21,
    S22    = 6'd22,
    S23    = 6'd23,
    S24    = 6'd24,
    S25    = 6'd25,
    S26    = 6'd26,
    S27    = 6'd27,
    S28    = 6'd28,
    S29    = 6'd29,
    S30    = 6'd30,
    S31    = 6'd31,
    S32    = 6'd32,
    S33    = 6'd33,
    S35    = 6'd35,
    S_HALT = 6'd40,
    S_ILL  = 6'd41,
    S_P1   = 6'd42,
    S_P2   = 6'd43
  } state_e;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam logic [1:0] PC_INC   = 2'b00;
  localparam logic [1:0] PC_ADDER = 2'b01;
  localparam logic [1:0] PC_BUS   = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

endpackage

// File: rtl/lc3_wait_ctr.sv
// SRAM wait-state counter. Ports: Clk, clr (sync clear),
// done (high on the last cycle of a MEM_WAIT-cycle access).
module lc3_wait_ctr #(
  parameter int MEM_WAIT = 3
) (
  input  logic Clk,
  input  logic clr,
  output logic done
);

  localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

  logic [3:0] cnt;

  always_ff @(posedge Clk) begin
    if (clr) cnt <= 4'd0;
    else     cnt <= cnt + 4'd1;
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/lc3_ctrl_seq.sv
// LC-3 Moore control sequencer with MEM_WAIT-cycle SRAM accesses.
// Ports: Clk, Reset (sync, high), Run, Continue, Opcode, IR_5, IR_11,
// BEN in; datapath loads, bus gates, mux selects, ALUK, Mem_OE/WE,
// Illegal out. Define LC3_PAUSE_EN to enable the 1101 pause opcode.
module lc3_ctrl_seq
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       MARMUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Illegal
);

  state_e state, state_n;
  logic   done, mem_st, clr;

`ifndef LC3_PAUSE_EN
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  assign mem_st = (state == S33) || (state == S25) ||
                  (state == S24) || (state == S28) ||
                  (state == S29) || (state == S16);

  // Counter restarts on every state entry, so it reads 0
  // in the first cycle of each memory access.
  assign clr = Reset || !mem_st || (state_n != state);

  lc3_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clk  (Clk),
    .clr  (clr),
    .done (done)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_HALT;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PC_INC;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = A2_ZERO;
    MARMUX     = 1'b0;
    ALUK       = ALU_ADD;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    Illegal    = 1'b0;
    unique case (state)
      S_HALT: if (Run) state_n = S18;
      S18: begin
        LD_MAR = 1'b1; GatePC = 1'b1; LD_PC = 1'b1;
        state_n = S33;
      end
      S33: begin
        Mem_OE = 1'b1; LD_MDR = done;
        if (done) state_n = S35;
      end
      S35: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        state_n = S32;
      end
      S32: begin
        LD_BEN = 1'b1;
        unique case (Opcode)
          OP_ADD:  state_n = S01;
          OP_AND:  state_n = S05;
          OP_NOT:  state_n = S09;
          OP_BR:   state_n = S00;
          OP_JMP:  state_n = S12;
          OP_JSR:  state_n = S04;
          OP_LD:   state_n = S02;
          OP_LDR:  state_n = S06;
          OP_LDI:  state_n = S10;
          OP_ST:   state_n = S03;
          OP_STR:  state_n = S07;
          OP_STI:  state_n = S11;
          OP_LEA:  state_n = S14;
          OP_TRAP: state_n = S15;
`ifdef LC3_PAUSE_EN
          OP_RES:  state_n = S_P1;
`endif
          default: state_n = S_ILL;
        endcase
      end
      S01, S05, S09: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        ALUK = (state == S01) ? ALU_ADD :
               (state == S05) ? ALU_AND : ALU_NOT;
        SR2MUX = (state != S09) && IR_5;
        state_n = S18;
      end
      S00: state_n = BEN ? S22 : S18;
      S22: begin
        LD_PC = 1'b1; PCMUX = PC_ADDER; ADDR2MUX = A2_OFF9;
        state_n = S18;
      end
      S12, S20: begin
        LD_PC = 1'b1; PCMUX = PC_ADDER; ADDR1MUX = 1'b1;
        state_n = S18;
      end
      S04: begin
        LD_REG = 1'b1; DRMUX = 1'b1; GatePC = 1'b1;
        state_n = IR_11 ? S21 : S20;
      end
      S21: begin
        LD_PC = 1'b1; PCMUX = PC_ADDER; ADDR2MUX = A2_OFF11;
        state_n = S18;
      end
      S02, S03, S10, S11: begin
        LD_MAR = 1'b1; GateMARMUX = 1'b1; ADDR2MUX = A2_OFF9;
        state_n = (state == S02) ? S25 :
                  (state == S03) ? S23 :
                  (state == S10) ? S24 : S29;
      end
      S06, S07: begin
        LD_MAR = 1'b1; GateMARMUX = 1'b1;
        ADDR1MUX = 1'b1; ADDR2MUX = A2_OFF6;
        state_n = (state == S06) ? S25 : S23;
      end
      S24, S25, S28, S29: begin
        Mem_OE = 1'b1; LD_MDR = done;
        if (done)
          state_n = (state == S24) ? S26 :
                    (state == S25) ? S27 :
                    (state == S28) ? S30 : S31;
      end
      S26, S31: begin
        LD_MAR = 1'b1; GateMDR = 1'b1;
        state_n = (state == S26) ? S25 : S23;
      end
      S27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        state_n = S18;
      end
      S23: begin
        LD_MDR = 1'b1; SR1MUX = 1'b1;
        ALUK = ALU_PASS; GateALU = 1'b1;
        state_n = S16;
      end
      S16: begin
        Mem_WE = 1'b1;
        if (done) state_n = S18;
      end
      S14: begin
        LD_REG = 1'b1; LD_CC = 1'b1;
        GateMARMUX = 1'b1; ADDR2MUX = A2_OFF9;
        state_n = S18;
      end
      S15: begin
        LD_MAR = 1'b1; GateMARMUX = 1'b1; MARMUX = 1'b1;
        state_n = S28;
      end
      S30: begin
        GateMDR = 1'b1; LD_PC = 1'b1; PCMUX = PC_BUS;
        LD_REG = 1'b1; DRMUX = 1'b1;
        state_n = S18;
      end
      S_ILL: begin
        Illegal = 1'b1;
        state_n = S18;
      end
`ifdef LC3_PAUSE_EN
      S_P1: begin
        LD_LED = 1'b1;
        if (Continue) state_n = S_P2;
      end
      S_P2: if (!Continue) state_n = S18;
`endif
      default: state_n = S18;
    endcase
  end

endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Scoreboard bench for lc3_ctrl_seq: per-instruction control
// traces from a micro-op model, checked cycle by cycle.
module tb_lc3_ctrl_seq;

  localparam int MW = 3;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG;
  logic       LD_PC, LD_LED, GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MARMUX;
  logic       Mem_OE, Mem_WE, Illegal;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben;
    logic       ld_cc, ld_reg, ld_pc, ld_led;
    logic       g_pc, g_mdr, g_alu, g_mm;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, a1;
    logic [1:0] a2;
    logic       marmux;
    logic [1:0] aluk;
    logic       oe, we, ill;
  } ctl_t;

  ctl_t act, e_m;
  ctl_t q[$];
  ctl_t tr[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  lc3_ctrl_seq #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
    .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG),
    .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC),
    .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .MARMUX(MARMUX), .ALUK(ALUK),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Illegal(Illegal)
  );

  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG,
                LD_PC, LD_LED, GatePC, GateMDR, GateALU,
                GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                ADDR1MUX, ADDR2MUX, MARMUX, ALUK,
                Mem_OE, Mem_WE, Illegal};

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    cyc++;
    if (q.size() > 0) begin
      e_m = q.pop_front();
      n_tests++;
      if (act !== e_m) begin
        n_fail++;
        $display("FAIL ctl cyc=%0d got=%h exp=%h", cyc, act, e_m);
      end
      n_tests++;
      if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1 ||
          (Mem_OE && Mem_WE)) begin
        n_fail++;
        $display("FAIL bus cyc=%0d gates=%b oe=%b we=%b", cyc,
                 {GatePC, GateMDR, GateALU, GateMARMUX},
                 Mem_OE, Mem_WE);
      end
    end
  end

  // Micro-op bundles, named by the register transfer they perform.
  function automatic ctl_t pc_add(logic a1, logic [1:0] a2);
    ctl_t c = '0;
    c.ld_pc = 1'b1; c.pcmux = 2'b01; c.a1 = a1; c.a2 = a2;
    return c;
  endfunction

  function automatic ctl_t mar_ea(logic a1, logic [1:0] a2);
    ctl_t c = '0;
    c.ld_mar = 1'b1; c.g_mm = 1'b1; c.a1 = a1; c.a2 = a2;
    return c;
  endfunction

  function automatic ctl_t mar_mdr();
    ctl_t c = '0;
    c.ld_mar = 1'b1; c.g_mdr = 1'b1;
    return c;
  endfunction

  function automatic ctl_t reg_mdr();
    ctl_t c = '0;
    c.g_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t alu_wr(logic [1:0] k, logic imm);
    ctl_t c = '0;
    c.g_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
    c.aluk = k; c.sr2mux = imm;
    return c;
  endfunction

  task automatic mem_rd();
    ctl_t c;
    for (int i = 0; i < MW; i++) begin
      c = '0; c.oe = 1'b1; c.ld_mdr = (i == MW - 1);
      tr.push_back(c);
    end
  endtask

  task automatic store_tail();
    ctl_t c = '0;
    c.ld_mdr = 1'b1; c.sr1mux = 1'b1;
    c.aluk = 2'b11; c.g_alu = 1'b1;
    tr.push_back(c);
    for (int i = 0; i < MW; i++) begin
      c = '0; c.we = 1'b1;
      tr.push_back(c);
    end
  endtask

  task automatic build(input logic [3:0] op, input logic ir5,
                       input logic ir11, input logic ben);
    ctl_t c;
    tr.delete();
    c = '0; c.ld_mar = 1'b1; c.g_pc = 1'b1; c.ld_pc = 1'b1;
    tr.push_back(c);
    mem_rd();
    c = '0; c.g_mdr = 1'b1; c.ld_ir = 1'b1;
    tr.push_back(c);
    c = '0; c.ld_ben = 1'b1;
    tr.push_back(c);
    case (op)
      4'h1: tr.push_back(alu_wr(2'b00, ir5));
      4'h5: tr.push_back(alu_wr(2'b01, ir5));
      4'h9: tr.push_back(alu_wr(2'b10, 1'b0));
      4'h0: begin
        tr.push_back('0);
        if (ben) tr.push_back(pc_add(1'b0, 2'b10));
      end
      4'hC: tr.push_back(pc_add(1'b1, 2'b00));
      4'h4: begin
        c = '0; c.ld_reg = 1'b1; c.drmux = 1'b1; c.g_pc = 1'b1;
        tr.push_back(c);
        tr.push_back(ir11 ? pc_add(1'b0, 2'b11)
                          : pc_add(1'b1, 2'b00));
      end
      4'h2, 4'h6: begin
        tr.push_back(op == 4'h2 ? mar_ea(1'b0, 2'b10)
                                : mar_ea(1'b1, 2'b01));
        mem_rd();
        tr.push_back(reg_mdr());
      end
      4'hA: begin
        tr.push_back(mar_ea(1'b0, 2'b10));
        mem_rd();
        tr.push_back(mar_mdr());
        mem_rd();
        tr.push_back(reg_mdr());
      end
      4'h3: begin tr.push_back(mar_ea(1'b0, 2'b10)); store_tail(); end
      4'h7: begin tr.push_back(mar_ea(1'b1, 2'b01)); store_tail(); end
      4'hB: begin
        tr.push_back(mar_ea(1'b0, 2'b10));
        mem_rd();
        tr.push_back(mar_mdr());
        store_tail();
      end
      4'hE: begin
        c = mar_ea(1'b0, 2'b10); c.ld_mar = 1'b0;
        c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        tr.push_back(c);
      end
      4'hF: begin
        c = '0; c.ld_mar = 1'b1; c.g_mm = 1'b1; c.marmux = 1'b1;
        tr.push_back(c);
        mem_rd();
        c = '0; c.g_mdr = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b10;
        c.ld_reg = 1'b1; c.drmux = 1'b1;
        tr.push_back(c);
      end
      default: begin
        c = '0; c.ill = 1'b1;
        tr.push_back(c);
      end
    endcase
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge Clk);
      n++;
    end while (q.size() != 0 && n < 200);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain timeout left=%0d need=0", q.size());
      q.delete();
    end
    #1;
  endtask

  task automatic restart();
    Run = 1'b0;
    q.push_back('0);
    q.push_back('0);
    drain();
    Run = 1'b1;
    q.push_back('0);
    drain();
  endtask

  task automatic run_instr(input logic [3:0] op, input logic ir5,
                           input logic ir11, input logic ben,
                           input int cut);
    Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
    Run = 1'($urandom); Continue = 1'($urandom);
    build(op, ir5, ir11, ben);
    if (cut < 0 || cut >= tr.size()) begin
      foreach (tr[i]) q.push_back(tr[i]);
      drain();
    end else begin
      for (int i = 0; i < cut; i++) q.push_back(tr[i]);
      if (cut > 0) drain();
      Reset = 1'b1;
      q.push_back(tr[cut]);
      drain();
      Reset = 1'b0;
      restart();
    end
  endtask

  function automatic logic [3:0] pick_op();
    logic [3:0] op = 4'($urandom);
`ifdef LC3_PAUSE_EN
    if (op == 4'hD) op = 4'h8;
`endif
    return op;
  endfunction

  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    Opcode = 4'h0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    restart();
    run_instr(4'h1, 1'b1, 1'b0, 1'b0, -1);
    run_instr(4'h0, 1'b0, 1'b0, 1'b0, -1);
    run_instr(4'h0, 1'b0, 1'b0, 1'b1, -1);
    run_instr(4'hA, 1'b0, 1'b0, 1'b0, -1);
    run_instr(4'hB, 1'b0, 1'b0, 1'b0, -1);
    run_instr(4'hF, 1'b0, 1'b0, 1'b0, -1);
    run_instr(4'h8, 1'b0, 1'b0, 1'b0, -1);
    run_instr(4'h4, 1'b0, 1'b1, 1'b0, -1);
    run_instr(4'h4, 1'b0, 1'b0, 1'b0, -1);
`ifndef LC3_PAUSE_EN
    run_instr(4'hD, 1'b0, 1'b0, 1'b0, -1);
`endif
    build(4'hB, 1'b0, 1'b0, 1'b0);
    run_instr(4'hB, 1'b0, 1'b0, 1'b0, tr.size() - MW + 1);
    for (int k = 0; k < 150; k++) begin
      logic [3:0] op;
      int cut;
      op = pick_op();
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : -1;
      run_instr(op, 1'($urandom), 1'($urandom), 1'($urandom), cut);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
